// File: rtl/stg_ma_pkg.sv
// Shared types for the amber memory-access stage: widths, opcode groups,
// FSM state encoding and the pipeline sideband record.
package stg_ma_pkg;

    localparam int HBIT_ADDR   = 47;
    localparam int HBIT_DATA   = 23;
    localparam int HBIT_OPC    = 5;
    localparam int HBIT_TGT_GP = 3;
    localparam int HBIT_TGT_SR = 1;
    localparam int HBIT_TGT_AR = 1;

    localparam logic [HBIT_OPC:0] OPC_NOP = 6'h00;
    localparam logic [HBIT_OPC:0] OPC_LD  = 6'h10;
    localparam logic [HBIT_OPC:0] OPC_LDU = 6'h11;
    localparam logic [HBIT_OPC:0] OPC_ST  = 6'h18;
    localparam logic [HBIT_OPC:0] OPC_STU = 6'h19;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_BUSY = 2'd1,
        MA_DONE = 2'd2
    } ma_state_t;

    typedef struct packed {
        logic [HBIT_ADDR:0]   pc;
        logic [HBIT_DATA:0]   instr;
        logic [HBIT_OPC:0]    opc;
        logic [HBIT_TGT_GP:0] tgt_gp;
        logic                 tgt_gp_we;
        logic [HBIT_TGT_SR:0] tgt_sr;
        logic                 tgt_sr_we;
        logic [HBIT_TGT_AR:0] tgt_ar;
        logic                 tgt_ar_we;
        logic [HBIT_DATA:0]   result;
        logic [HBIT_ADDR:0]   ar_result;
        logic [HBIT_ADDR:0]   sr_result;
    } ma_sb_t;

    function automatic logic is_ld(input logic [HBIT_OPC:0] opc);
        return (opc == OPC_LD) || (opc == OPC_LDU);
    endfunction

    function automatic logic is_st(input logic [HBIT_OPC:0] opc);
        return (opc == OPC_ST) || (opc == OPC_STU);
    endfunction

    function automatic ma_sb_t kill_we(input ma_sb_t s);
        ma_sb_t r;
        r           = s;
        r.tgt_gp_we = 1'b0;
        r.tgt_sr_we = 1'b0;
        r.tgt_ar_we = 1'b0;
        return r;
    endfunction

    // A bubble keeps the sideband fields but can never write anything back.
    function automatic ma_sb_t make_bubble(input ma_sb_t s);
        ma_sb_t r;
        r     = kill_we(s);
        r.opc = OPC_NOP;
        return r;
    endfunction

endpackage

// File: rtl/ma_mem_if.sv
// Data-memory req/ack engine for stg_ma: request FSM, address/data latches
// and, when MA_TIMEOUT_EN is defined, a watchdog that abandons a silent access.
module ma_mem_if
    import stg_ma_pkg::*;
#(
    parameter int TO_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               we_i,
    input  logic [HBIT_ADDR:0] addr_i,
    input  logic [HBIT_DATA:0] wdata_i,
    input  logic               stall_i,
    input  logic               ack_i,
    input  logic [HBIT_DATA:0] rdata_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [HBIT_ADDR:0] mem_addr_o,
    output logic [HBIT_DATA:0] mem_wdata_o,
`ifdef MA_TIMEOUT_EN
    output logic               bus_err_o,
`endif
    output ma_state_t          state_o,
    output logic               fin_o,
    output logic [HBIT_DATA:0] fin_data_o,
    output logic               fin_err_o
);

    if (TO_CYCLES < 1) begin : g_bad_to_cycles
        $error("TO_CYCLES must be positive");
    end

    ma_state_t          state_q;
    logic               req_q;
    logic               we_q;
    logic [HBIT_ADDR:0] addr_q;
    logic [HBIT_DATA:0] wdata_q;
    logic [HBIT_DATA:0] data_q;
    logic               err_q;
    logic               timeout;

`ifdef MA_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES) + 1;
    logic [CW-1:0] cnt_q;
    logic          bus_err_q;

    assign timeout   = (state_q == MA_BUSY) && !ack_i && (cnt_q == CW'(TO_CYCLES - 1));
    assign bus_err_o = bus_err_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= MA_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
`ifdef MA_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
`ifdef MA_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state_q)
                MA_IDLE: begin
                    if (start_i) begin
                        state_q <= MA_BUSY;
                        req_q   <= 1'b1;
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
`ifdef MA_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                MA_BUSY: begin
                    if (ack_i || timeout) begin
                        req_q   <= 1'b0;
                        data_q  <= ack_i ? rdata_i : '0;
                        err_q   <= !ack_i;
                        state_q <= stall_i ? MA_DONE : MA_IDLE;
`ifdef MA_TIMEOUT_EN
                        bus_err_q <= timeout;
`endif
                    end
`ifdef MA_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                MA_DONE: begin
                    if (!stall_i) begin
                        state_q <= MA_IDLE;
                    end
                end
                default: state_q <= MA_IDLE;
            endcase
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign state_o     = state_q;

    // Completion is visible in the same cycle it happens so the parent can
    // load its output registers on that edge instead of one later.
    assign fin_o      = ((state_q == MA_BUSY) && (ack_i || timeout) && !stall_i)
                     || ((state_q == MA_DONE) && !stall_i);
    assign fin_data_o = (state_q == MA_BUSY) ? (ack_i ? rdata_i : '0) : data_q;
    assign fin_err_o  = (state_q == MA_BUSY) ? !ack_i : err_q;

endmodule

// File: rtl/stg_ma.sv
// amber memory-access stage: pipeline registers, bubble insertion and stall.
// Define MA_TIMEOUT_EN to add the access watchdog and the ow_bus_err port.
module stg_ma
    import stg_ma_pkg::*;
#(
    parameter int TO_CYCLES = 64
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic [HBIT_ADDR:0]   iw_pc,
    input  logic [HBIT_DATA:0]   iw_instr,
    input  logic [HBIT_OPC:0]    iw_opc,
    input  logic [HBIT_TGT_GP:0] iw_tgt_gp,
    input  logic                 iw_tgt_gp_we,
    input  logic [HBIT_TGT_SR:0] iw_tgt_sr,
    input  logic                 iw_tgt_sr_we,
    input  logic [HBIT_TGT_AR:0] iw_tgt_ar,
    input  logic                 iw_tgt_ar_we,
    input  logic [HBIT_ADDR:0]   iw_addr,
    input  logic [HBIT_DATA:0]   iw_result,
    input  logic [HBIT_ADDR:0]   iw_ar_result,
    input  logic [HBIT_ADDR:0]   iw_sr_result,
    input  logic                 iw_mem_ack,
    input  logic [HBIT_DATA:0]   iw_mem_rdata,
    input  logic                 iw_flush,
    input  logic                 iw_stall,
    output logic [HBIT_ADDR:0]   ow_pc,
    output logic [HBIT_DATA:0]   ow_instr,
    output logic [HBIT_OPC:0]    ow_opc,
    output logic [HBIT_TGT_GP:0] ow_tgt_gp,
    output logic                 ow_tgt_gp_we,
    output logic [HBIT_TGT_SR:0] ow_tgt_sr,
    output logic                 ow_tgt_sr_we,
    output logic [HBIT_TGT_AR:0] ow_tgt_ar,
    output logic                 ow_tgt_ar_we,
    output logic [HBIT_DATA:0]   ow_result,
    output logic [HBIT_ADDR:0]   ow_ar_result,
    output logic [HBIT_ADDR:0]   ow_sr_result,
    output logic                 ow_mem_req,
    output logic                 ow_mem_we,
    output logic [HBIT_ADDR:0]   ow_mem_addr,
    output logic [HBIT_DATA:0]   ow_mem_wdata,
`ifdef MA_TIMEOUT_EN
    output logic                 ow_bus_err,
`endif
    output logic                 ow_stall
);

    ma_sb_t             in_sb;
    ma_sb_t             out_q, out_d;
    ma_sb_t             hold_q, hold_d;
    ma_state_t          mem_state;
    logic               is_mem;
    logic               start;
    logic               fin;
    logic               fin_err;
    logic [HBIT_DATA:0] fin_data;

    always_comb begin
        in_sb           = '0;
        in_sb.pc        = iw_pc;
        in_sb.instr     = iw_instr;
        in_sb.opc       = iw_opc;
        in_sb.tgt_gp    = iw_tgt_gp;
        in_sb.tgt_gp_we = iw_tgt_gp_we;
        in_sb.tgt_sr    = iw_tgt_sr;
        in_sb.tgt_sr_we = iw_tgt_sr_we;
        in_sb.tgt_ar    = iw_tgt_ar;
        in_sb.tgt_ar_we = iw_tgt_ar_we;
        in_sb.result    = iw_result;
        in_sb.ar_result = iw_ar_result;
        in_sb.sr_result = iw_sr_result;
    end

    assign is_mem = is_ld(iw_opc) || is_st(iw_opc);
    assign start  = (mem_state == MA_IDLE) && !iw_stall && !iw_flush && is_mem;

    ma_mem_if #(
        .TO_CYCLES (TO_CYCLES)
    ) u_mem_if (
        .clk_i       (iw_clk),
        .rst_ni      (iw_rst),
        .start_i     (start),
        .we_i        (is_st(iw_opc)),
        .addr_i      (iw_addr),
        .wdata_i     (iw_result),
        .stall_i     (iw_stall),
        .ack_i       (iw_mem_ack),
        .rdata_i     (iw_mem_rdata),
        .mem_req_o   (ow_mem_req),
        .mem_we_o    (ow_mem_we),
        .mem_addr_o  (ow_mem_addr),
        .mem_wdata_o (ow_mem_wdata),
`ifdef MA_TIMEOUT_EN
        .bus_err_o   (ow_bus_err),
`endif
        .state_o     (mem_state),
        .fin_o       (fin),
        .fin_data_o  (fin_data),
        .fin_err_o   (fin_err)
    );

    // A finishing access owns the output registers; otherwise only an
    // unstalled IDLE cycle may load new work. BUSY/DONE ignore flush.
    always_comb begin
        out_d  = out_q;
        hold_d = hold_q;
        if (fin) begin
            out_d = hold_q;
            if (fin_err) begin
                out_d        = kill_we(hold_q);
                out_d.result = '0;
            end else if (is_ld(hold_q.opc)) begin
                out_d.result = fin_data;
            end else begin
                out_d = kill_we(hold_q);
            end
        end else if ((mem_state == MA_IDLE) && !iw_stall) begin
            if (iw_flush || is_mem) begin
                out_d = make_bubble(in_sb);
            end else begin
                out_d = in_sb;
            end
            if (start) begin
                hold_d = in_sb;
            end
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            out_q  <= '0;
            hold_q <= '0;
        end else begin
            out_q  <= out_d;
            hold_q <= hold_d;
        end
    end

    assign ow_pc        = out_q.pc;
    assign ow_instr     = out_q.instr;
    assign ow_opc       = out_q.opc;
    assign ow_tgt_gp    = out_q.tgt_gp;
    assign ow_tgt_gp_we = out_q.tgt_gp_we;
    assign ow_tgt_sr    = out_q.tgt_sr;
    assign ow_tgt_sr_we = out_q.tgt_sr_we;
    assign ow_tgt_ar    = out_q.tgt_ar;
    assign ow_tgt_ar_we = out_q.tgt_ar_we;
    assign ow_result    = out_q.result;
    assign ow_ar_result = out_q.ar_result;
    assign ow_sr_result = out_q.sr_result;

    // Held low during reset so every output reads 0 while iw_rst is asserted.
    assign ow_stall = iw_rst && ((mem_state != MA_IDLE) || iw_stall);

endmodule
